// File: rtl/axi_to_mem_bridge.sv
// AXI4 slave to req/gnt/valid memory bridge.
// Each AXI burst beat becomes one single-beat memory request, and only one
// burst is in flight at a time. WRAP and the reserved burst encoding step
// through addresses exactly as INCR does. The beat count comes from AxLEN;
// WLAST is not used.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for AW/AR; arbitrates when both arrive together
// RD_REQ   | read request on the mem port, held until granted
// RD_WAIT  | waiting for the read response
// RD_DATA  | R beat presented; waits for rready before the next request
// WR_REQ   | write request driven from the W channel, held until granted
// WR_WAIT  | waiting for the write response; accumulates the error
// WR_RESP  | B response presented; waits for bready
module axi_to_mem_bridge #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 3,
    parameter int MEM_ADDR_WIDTH = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [AXI_ID_WIDTH-1:0]     s_axi_awid,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]                  s_axi_awlen,
    input  logic [2:0]                  s_axi_awsize,
    input  logic [1:0]                  s_axi_awburst,
    input  logic                        s_axi_awlock,
    input  logic [3:0]                  s_axi_awcache,
    input  logic [2:0]                  s_axi_awprot,
    input  logic [3:0]                  s_axi_awqos,
    input  logic [3:0]                  s_axi_awregion,
    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                        s_axi_wlast,
    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    output logic [AXI_ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]                  s_axi_bresp,
    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,
    input  logic [AXI_ID_WIDTH-1:0]     s_axi_arid,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]                  s_axi_arlen,
    input  logic [2:0]                  s_axi_arsize,
    input  logic [1:0]                  s_axi_arburst,
    input  logic                        s_axi_arlock,
    input  logic [3:0]                  s_axi_arcache,
    input  logic [2:0]                  s_axi_arprot,
    input  logic [3:0]                  s_axi_arqos,
    input  logic [3:0]                  s_axi_arregion,
    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,
    output logic [AXI_ID_WIDTH-1:0]     s_axi_rid,
    output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                  s_axi_rresp,
    output logic                        s_axi_rlast,
    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready,
    output logic                        m_mem_req,
    input  logic                        m_mem_gnt,
    output logic [MEM_ADDR_WIDTH-1:0]   m_mem_addr,
    output logic                        m_mem_we,
    output logic [AXI_DATA_WIDTH-1:0]   m_mem_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] m_mem_be,
    input  logic                        m_mem_valid,
    input  logic [AXI_DATA_WIDTH-1:0]   m_mem_rdata,
    input  logic                        m_mem_error
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_REQ  = 3'd1;
    localparam logic [2:0] ST_RD_WAIT = 3'd2;
    localparam logic [2:0] ST_RD_DATA = 3'd3;
    localparam logic [2:0] ST_WR_REQ  = 3'd4;
    localparam logic [2:0] ST_WR_WAIT = 3'd5;
    localparam logic [2:0] ST_WR_RESP = 3'd6;

    localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_ONE = {{(AXI_ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [2:0]                  state_q;
    logic [AXI_ID_WIDTH-1:0]     id_q;
    logic [AXI_ADDR_WIDTH-1:0]   addr_q;
    logic [7:0]                  len_q;
    logic [2:0]                  size_q;
    logic [1:0]                  burst_q;
    logic [7:0]                  beat_q;
    logic                        err_q;
    logic [AXI_DATA_WIDTH-1:0]   rdata_q;
    logic                        prio_rd_q;

    logic                        sel_wr;
    logic                        sel_rd;
    logic                        last_beat;
    logic [AXI_ADDR_WIDTH-1:0]   addr_step;
    logic                        unused_inputs;

    // Write wins unless both channels are valid and the read holds priority.
    assign sel_wr    = s_axi_awvalid & (~s_axi_arvalid | ~prio_rd_q);
    assign sel_rd    = s_axi_arvalid & ~sel_wr;
    assign last_beat = (beat_q == len_q);
    assign addr_step = (burst_q == 2'b00) ? '0 : (ADDR_ONE << size_q);

    assign s_axi_awready = (state_q == ST_IDLE) & sel_wr;
    assign s_axi_arready = (state_q == ST_IDLE) & sel_rd;

    assign s_axi_wready  = (state_q == ST_WR_REQ) & m_mem_gnt;
    assign s_axi_bvalid  = (state_q == ST_WR_RESP);
    assign s_axi_bid     = id_q;
    assign s_axi_bresp   = err_q ? 2'b10 : 2'b00;

    assign s_axi_rvalid  = (state_q == ST_RD_DATA);
    assign s_axi_rid     = id_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = err_q ? 2'b10 : 2'b00;
    assign s_axi_rlast   = last_beat;

    assign m_mem_req   = (state_q == ST_RD_REQ) | ((state_q == ST_WR_REQ) & s_axi_wvalid);
    assign m_mem_we    = (state_q == ST_WR_REQ);
    assign m_mem_addr  = addr_q[MEM_ADDR_WIDTH-1:0];
    assign m_mem_wdata = s_axi_wdata;
    assign m_mem_be    = (state_q == ST_WR_REQ) ? s_axi_wstrb : '1;

    assign unused_inputs = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos,
                             s_axi_awregion, s_axi_arlock, s_axi_arcache, s_axi_arprot,
                             s_axi_arqos, s_axi_arregion, s_axi_wlast};

    // Burst sequencing: one mem request per beat, one burst in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            beat_q    <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            prio_rd_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (s_axi_awvalid && s_axi_arvalid) begin
                        prio_rd_q <= sel_wr;
                    end
                    if (sel_wr) begin
                        id_q    <= s_axi_awid;
                        addr_q  <= s_axi_awaddr;
                        len_q   <= s_axi_awlen;
                        size_q  <= s_axi_awsize;
                        burst_q <= s_axi_awburst;
                        beat_q  <= '0;
                        err_q   <= 1'b0;
                        state_q <= ST_WR_REQ;
                    end else if (sel_rd) begin
                        id_q    <= s_axi_arid;
                        addr_q  <= s_axi_araddr;
                        len_q   <= s_axi_arlen;
                        size_q  <= s_axi_arsize;
                        burst_q <= s_axi_arburst;
                        beat_q  <= '0;
                        err_q   <= 1'b0;
                        state_q <= ST_RD_REQ;
                    end
                end
                ST_RD_REQ: begin
                    if (m_mem_gnt) begin
                        state_q <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (m_mem_valid) begin
                        rdata_q <= m_mem_rdata;
                        err_q   <= m_mem_error;
                        state_q <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (s_axi_rready) begin
                        if (last_beat) begin
                            state_q <= ST_IDLE;
                        end else begin
                            beat_q  <= beat_q + 8'd1;
                            addr_q  <= addr_q + addr_step;
                            state_q <= ST_RD_REQ;
                        end
                    end
                end
                ST_WR_REQ: begin
                    if (s_axi_wvalid && m_mem_gnt) begin
                        state_q <= ST_WR_WAIT;
                    end
                end
                ST_WR_WAIT: begin
                    if (m_mem_valid) begin
                        err_q <= err_q | m_mem_error;
                        if (last_beat) begin
                            state_q <= ST_WR_RESP;
                        end else begin
                            beat_q  <= beat_q + 8'd1;
                            addr_q  <= addr_q + addr_step;
                            state_q <= ST_WR_REQ;
                        end
                    end
                end
                ST_WR_RESP: begin
                    if (s_axi_bready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_to_mem_bridge.sv
// Bench for axi_to_mem_bridge: a transaction-level model builds the expected
// mem requests, R beats and B responses from each address handshake, and a
// negedge compare process checks the DUT against it every cycle.
module tb_axi_to_mem_bridge;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [2:0]  s_axi_awid, s_axi_arid, s_axi_bid, s_axi_rid;
    logic [31:0] s_axi_awaddr, s_axi_araddr;
    logic [7:0]  s_axi_awlen, s_axi_arlen;
    logic [2:0]  s_axi_awsize, s_axi_arsize;
    logic [1:0]  s_axi_awburst, s_axi_arburst;
    logic        s_axi_awvalid, s_axi_awready, s_axi_arvalid, s_axi_arready;
    logic [31:0] s_axi_wdata, s_axi_rdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wlast, s_axi_wvalid, s_axi_wready;
    logic [1:0]  s_axi_bresp, s_axi_rresp;
    logic        s_axi_bvalid, s_axi_bready;
    logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;
    logic        m_mem_req, m_mem_gnt, m_mem_we, m_mem_valid, m_mem_error;
    logic [31:0] m_mem_addr, m_mem_wdata, m_mem_rdata;
    logic [3:0]  m_mem_be;

    always #5 clk_i = ~clk_i;

    axi_to_mem_bridge dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(1'b0),
        .s_axi_awcache(4'h0), .s_axi_awprot(3'h0), .s_axi_awqos(4'h0), .s_axi_awregion(4'h0),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(1'b0),
        .s_axi_arcache(4'h0), .s_axi_arprot(3'h0), .s_axi_arqos(4'h0), .s_axi_arregion(4'h0),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .m_mem_req(m_mem_req), .m_mem_gnt(m_mem_gnt), .m_mem_addr(m_mem_addr),
        .m_mem_we(m_mem_we), .m_mem_wdata(m_mem_wdata), .m_mem_be(m_mem_be),
        .m_mem_valid(m_mem_valid), .m_mem_rdata(m_mem_rdata), .m_mem_error(m_mem_error)
    );

    typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } mem_op_t;
    typedef struct { logic [2:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_beat_t;
    typedef struct { logic [2:0] id; logic [1:0] resp; } b_rsp_t;

    mem_op_t     exp_mem[$];
    r_beat_t     exp_r[$];
    b_rsp_t      exp_b[$];
    logic [31:0] addr_log[$];
    logic [3:0]  be_log[$];
    byte         order_log[$];
    logic [31:0] wd [16];
    logic [3:0]  ws [16];

    int nvec = 0;
    int nfail = 0;
    int cyc = 0;
    int err_beat = -1;
    int gnt_delay = 0;
    int gidx = 0;
    int r_hs = 0;
    int rlast_cnt = 0;
    logic [31:0] last_rdata;
    logic [2:0]  last_rid;
    logic [1:0]  last_rresp, last_bresp;
    logic        last_rlast;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Memory contents seen by reads: a fixed function of the address.
    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
        return (a ^ 32'h5A5A_0000) + 32'h0000_1234;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        nvec++;
        nfail++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    // Memory target: optional grant wait states, response one cycle after grant.
    logic        pend = 1'b0;
    logic        pend_err;
    logic [31:0] pend_data;
    int          wcnt = 0;
    initial begin
        m_mem_gnt = 1'b0; m_mem_valid = 1'b0; m_mem_rdata = 32'h0; m_mem_error = 1'b0;
        forever begin
            @(posedge clk_i); #2;
            if (rst_i) begin
                pend = 1'b0; wcnt = 0;
                m_mem_gnt = 1'b0; m_mem_valid = 1'b0; m_mem_error = 1'b0;
            end else begin
                m_mem_valid = pend;
                m_mem_rdata = pend ? pend_data : 32'h0;
                m_mem_error = pend & pend_err;
                pend = 1'b0;
                m_mem_gnt = 1'b0;
                if (m_mem_req) begin
                    if (wcnt < gnt_delay) begin
                        wcnt++;
                    end else begin
                        wcnt = 0;
                        m_mem_gnt = 1'b1;
                        pend = 1'b1;
                        pend_data = m_mem_we ? 32'h0 : mem_val(m_mem_addr);
                        pend_err = (gidx == err_beat);
                        gidx++;
                    end
                end
            end
        end
    end

    // Model expansion on address handshakes and per-cycle output checks.
    mem_op_t     op;
    r_beat_t     rb;
    b_rsp_t      bb;
    logic [31:0] m_a, m_step;
    logic        prev_stall = 1'b0, prev_rwait = 1'b0;
    logic [31:0] prev_addr, prev_rdata;
    always @(negedge clk_i) begin
        if (rst_i) begin
            exp_mem.delete(); exp_r.delete(); exp_b.delete();
            prev_stall = 1'b0; prev_rwait = 1'b0;
        end else begin
            if (s_axi_arvalid && s_axi_arready) begin
                order_log.push_back(8'h52);
                gidx = 0;
                m_a = s_axi_araddr;
                m_step = (s_axi_arburst == 2'b00) ? 32'd0 : (32'd1 << s_axi_arsize);
                for (int i = 0; i <= int'(s_axi_arlen); i++) begin
                    exp_mem.push_back('{m_a, 1'b0, 4'hF, 32'h0});
                    exp_r.push_back('{s_axi_arid, mem_val(m_a), ((i == err_beat) ? 2'b10 : 2'b00),
                                      (i == int'(s_axi_arlen))});
                    m_a = m_a + m_step;
                end
            end
            if (s_axi_awvalid && s_axi_awready) begin
                order_log.push_back(8'h57);
                gidx = 0;
                m_a = s_axi_awaddr;
                m_step = (s_axi_awburst == 2'b00) ? 32'd0 : (32'd1 << s_axi_awsize);
                for (int i = 0; i <= int'(s_axi_awlen); i++) begin
                    exp_mem.push_back('{m_a, 1'b1, ws[i], wd[i]});
                    m_a = m_a + m_step;
                end
                exp_b.push_back('{s_axi_awid, ((err_beat >= 0 && err_beat <= int'(s_axi_awlen)) ? 2'b10 : 2'b00)});
            end
            if (prev_stall) begin
                check("req_held_until_gnt", m_mem_req, 1);
                check("addr_held_until_gnt", m_mem_addr, prev_addr);
            end
            if (m_mem_req && m_mem_gnt) begin
                if (exp_mem.size() == 0) begin
                    check("unexpected_mem_req", 1, 0);
                end else begin
                    op = exp_mem.pop_front();
                    check("mem_addr", m_mem_addr, op.addr);
                    check("mem_we", m_mem_we, op.we);
                    check("mem_be", m_mem_be, op.be);
                    if (op.we) check("mem_wdata", m_mem_wdata, op.wdata);
                    addr_log.push_back(m_mem_addr);
                    be_log.push_back(m_mem_be);
                end
            end
            if (s_axi_rvalid) begin
                check("no_req_while_rvalid", m_mem_req, 0);
                if (prev_rwait) check("rdata_stable", s_axi_rdata, prev_rdata);
            end
            if (s_axi_rvalid && s_axi_rready) begin
                if (exp_r.size() == 0) begin
                    check("unexpected_r_beat", 1, 0);
                end else begin
                    rb = exp_r.pop_front();
                    check("rid", s_axi_rid, rb.id);
                    check("rdata", s_axi_rdata, rb.data);
                    check("rresp", s_axi_rresp, rb.resp);
                    check("rlast", s_axi_rlast, rb.last);
                end
                r_hs++;
                if (s_axi_rlast) rlast_cnt++;
                last_rdata = s_axi_rdata; last_rid = s_axi_rid;
                last_rresp = s_axi_rresp; last_rlast = s_axi_rlast;
            end
            if (s_axi_bvalid && s_axi_bready) begin
                if (exp_b.size() == 0) begin
                    check("unexpected_b", 1, 0);
                end else begin
                    bb = exp_b.pop_front();
                    check("bid", s_axi_bid, bb.id);
                    check("bresp", s_axi_bresp, bb.resp);
                end
                last_bresp = s_axi_bresp;
            end
            prev_stall = m_mem_req && !m_mem_gnt;
            prev_addr  = m_mem_addr;
            prev_rwait = s_axi_rvalid && !s_axi_rready;
            prev_rdata = s_axi_rdata;
        end
    end

    task automatic do_read(input logic [2:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int hold_beat,
                           input int hold_cyc, output int lat, output int ar_wait);
        int t;
        int c0;
        lat = -1; ar_wait = -1;
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
        s_axi_arsize = size; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
        t = 0;
        @(negedge clk_i);
        while (!s_axi_arready && t < 300) begin @(negedge clk_i); t++; end
        if (!s_axi_arready) begin timeout_fail("ar_handshake"); s_axi_arvalid = 1'b0; return; end
        ar_wait = t; c0 = cyc;
        @(posedge clk_i); #1 s_axi_arvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            t = 0;
            @(negedge clk_i);
            while (!s_axi_rvalid && t < 100) begin @(negedge clk_i); t++; end
            if (!s_axi_rvalid) begin timeout_fail("r_beat"); return; end
            if (b == 0) lat = cyc - c0;
            if (b == hold_beat) repeat (hold_cyc) @(negedge clk_i);
            @(posedge clk_i); #1 s_axi_rready = 1'b1;
            @(posedge clk_i); #1 s_axi_rready = 1'b0;
        end
    endtask

    task automatic do_write(input logic [2:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, output int blat);
        int t;
        int c0;
        blat = -1;
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
        s_axi_awsize = size; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
        t = 0;
        @(negedge clk_i);
        while (!s_axi_awready && t < 300) begin @(negedge clk_i); t++; end
        if (!s_axi_awready) begin timeout_fail("aw_handshake"); s_axi_awvalid = 1'b0; return; end
        c0 = cyc;
        @(posedge clk_i); #1 s_axi_awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            s_axi_wvalid = 1'b1; s_axi_wdata = wd[b]; s_axi_wstrb = ws[b];
            s_axi_wlast = (b == int'(len));
            t = 0;
            @(negedge clk_i);
            while (!s_axi_wready && t < 100) begin @(negedge clk_i); t++; end
            if (!s_axi_wready) begin timeout_fail("w_beat"); s_axi_wvalid = 1'b0; return; end
            @(posedge clk_i); #1 s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
        end
        t = 0;
        @(negedge clk_i);
        while (!s_axi_bvalid && t < 100) begin @(negedge clk_i); t++; end
        if (!s_axi_bvalid) begin timeout_fail("b_response"); return; end
        blat = cyc - c0;
        @(posedge clk_i); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int lat, lat2, arw;
    initial begin
        rst_i = 1'b1;
        s_axi_awid = 0; s_axi_awaddr = 0; s_axi_awlen = 0; s_axi_awsize = 0; s_axi_awburst = 0;
        s_axi_awvalid = 0; s_axi_arid = 0; s_axi_araddr = 0; s_axi_arlen = 0; s_axi_arsize = 0;
        s_axi_arburst = 0; s_axi_arvalid = 0; s_axi_wdata = 0; s_axi_wstrb = 0; s_axi_wlast = 0;
        s_axi_wvalid = 0; s_axi_bready = 1'b1; s_axi_rready = 1'b0;
        for (int i = 0; i < 16; i++) begin wd[i] = 32'h0; ws[i] = 4'h0; end
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check("reset_rvalid", s_axi_rvalid, 0);
        check("reset_bvalid", s_axi_bvalid, 0);
        check("reset_wready", s_axi_wready, 0);
        check("reset_mem_req", m_mem_req, 0);
        check("reset_rresp", s_axi_rresp, 0);
        check("reset_bresp", s_axi_bresp, 0);
        check("reset_rdata", s_axi_rdata, 0);
        @(posedge clk_i); #1;

        // single read
        addr_log.delete();
        do_read(3'd5, 32'h100, 8'd0, 3'd2, 2'b01, -1, 0, lat, arw);
        check("t1_latency", lat, 3);
        check("t1_rdata", last_rdata, 32'hDEAD_BEEF);
        check("t1_rid", last_rid, 3'd5);
        check("t1_rresp", last_rresp, 2'b00);
        check("t1_rlast", last_rlast, 1'b1);
        check("t1_nreq", addr_log.size(), 1);
        check("t1_mem_addr", addr_log[0], 32'h100);

        // INCR read burst with rready stalled on beat 2
        addr_log.delete(); r_hs = 0; rlast_cnt = 0;
        do_read(3'd2, 32'h200, 8'd3, 3'd2, 2'b01, 1, 5, lat, arw);
        check("t2_nreq", addr_log.size(), 4);
        check("t2_addr0", addr_log[0], 32'h200);
        check("t2_addr1", addr_log[1], 32'h204);
        check("t2_addr2", addr_log[2], 32'h208);
        check("t2_addr3", addr_log[3], 32'h20C);
        check("t2_beats", r_hs, 4);
        check("t2_rlast_count", rlast_cnt, 1);

        // FIXED write burst
        addr_log.delete(); be_log.delete();
        wd[0] = 32'h1111_1111; wd[1] = 32'h2222_2222; wd[2] = 32'h3333_3333;
        ws[0] = 4'h3; ws[1] = 4'hF; ws[2] = 4'h8;
        do_write(3'd1, 32'h40, 8'd2, 3'd2, 2'b00, lat);
        check("t3_nreq", addr_log.size(), 3);
        for (int i = 0; i < 3; i++) check("t3_fixed_addr", addr_log[i], 32'h40);
        check("t3_be0", be_log[0], 4'h3);
        check("t3_be1", be_log[1], 4'hF);
        check("t3_be2", be_log[2], 4'h8);
        check("t3_bresp", last_bresp, 2'b00);

        // single write latency
        wd[0] = 32'hCAFE_0001; ws[0] = 4'hF;
        do_write(3'd6, 32'h1000, 8'd0, 3'd2, 2'b01, lat);
        check("single_write_latency", lat, 3);

        // write error on beat 2 of 4
        addr_log.delete();
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hA000_0000 + i; ws[i] = 4'hF; end
        err_beat = 1;
        do_write(3'd3, 32'h80, 8'd3, 3'd2, 2'b01, lat);
        err_beat = -1;
        check("t4_nreq", addr_log.size(), 4);
        check("t4_addr3", addr_log[3], 32'h8C);
        check("t4_bresp", last_bresp, 2'b10);

        // read error on beat 3 of 4: only that beat reports SLVERR
        err_beat = 2;
        do_read(3'd4, 32'h300, 8'd3, 3'd2, 2'b01, -1, 0, lat, arw);
        err_beat = -1;
        check("read_err_last_rresp", last_rresp, 2'b00);

        // WRAP treated as INCR, with grant wait states
        addr_log.delete();
        gnt_delay = 2;
        do_read(3'd0, 32'h3FE, 8'd1, 3'd1, 2'b10, -1, 0, lat, arw);
        gnt_delay = 0;
        check("wrap_addr0", addr_log[0], 32'h3FE);
        check("wrap_addr1", addr_log[1], 32'h400);

        // INCR wraps modulo 2^32
        addr_log.delete();
        do_read(3'd1, 32'hFFFF_FFFC, 8'd1, 3'd2, 2'b01, -1, 0, lat, arw);
        check("addr_wrap1", addr_log[1], 32'h0);
        check("addr_wrap_rdata", last_rdata, 32'h5A5A_1234);

        // arbitration: three simultaneous AW/AR pairs
        order_log.delete();
        wd[0] = 32'h5555_0000; wd[1] = 32'h5555_0001; ws[0] = 4'hF; ws[1] = 4'hC;
        for (int rep = 0; rep < 3; rep++) begin
            fork
                do_write(3'd4, 32'h500, 8'd1, 3'd2, 2'b01, lat);
                do_read(3'd7, 32'h600, 8'd1, 3'd2, 2'b01, -1, 0, lat2, arw);
            join
        end
        check("arb_events", order_log.size(), 6);
        check("arb_win1_write", order_log[0], 8'h57);
        check("arb_win2_read", order_log[2], 8'h52);
        check("arb_win3_write", order_log[4], 8'h57);
        check("arb_loser2", order_log[3], 8'h57);

        // reset during beat 2 of an 8-beat read
        s_axi_arid = 3'd1; s_axi_araddr = 32'h700; s_axi_arlen = 8'd7;
        s_axi_arsize = 3'd2; s_axi_arburst = 2'b01; s_axi_arvalid = 1'b1;
        begin : rst_test
            int t;
            t = 0;
            @(negedge clk_i);
            while (!s_axi_arready && t < 50) begin @(negedge clk_i); t++; end
            if (!s_axi_arready) timeout_fail("t6_ar");
            @(posedge clk_i); #1 s_axi_arvalid = 1'b0;
            for (int b = 0; b < 2; b++) begin
                t = 0;
                @(negedge clk_i);
                while (!s_axi_rvalid && t < 50) begin @(negedge clk_i); t++; end
                if (!s_axi_rvalid) timeout_fail("t6_r");
                if (b == 0) begin
                    @(posedge clk_i); #1 s_axi_rready = 1'b1;
                    @(posedge clk_i); #1 s_axi_rready = 1'b0;
                end
            end
            @(posedge clk_i); #1 rst_i = 1'b1;
            @(posedge clk_i); #1 rst_i = 1'b0;
            @(negedge clk_i);
            check("t6_rvalid_after_reset", s_axi_rvalid, 0);
            check("t6_req_after_reset", m_mem_req, 0);
            @(posedge clk_i); #1;
        end
        addr_log.delete();
        do_read(3'd2, 32'h900, 8'd1, 3'd2, 2'b01, -1, 0, lat, arw);
        check("t6_ar_immediate", arw, 0);
        check("t6_latency", lat, 3);
        check("t6_addr1", addr_log[1], 32'h904);
        check("t6_rdata", last_rdata, 32'h5A5A_1B38);
        check("t6_rid", last_rid, 3'd2);

        repeat (3) @(posedge clk_i);
        check("left_mem_ops", exp_mem.size(), 0);
        check("left_r_beats", exp_r.size(), 0);
        check("left_b_rsps", exp_b.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/axi_to_mem_bridge.md
Name: axi_to_mem_bridge

Overview:
- AXI4 full slave that converts AXI bursts into single-beat transactions on the codebase memory protocol (req/gnt/valid).
- It is the reverse of the mem-to-AXI master bridge.
- It sits between a crossbar master port and an SRAM-style peripheral or memory controller.
- One transaction is in flight at a time, and each burst beat becomes exactly one mem request.

Parameters:
- AXI_ADDR_WIDTH, 32, AXI address width.
- AXI_DATA_WIDTH, 32, AXI data width; equals the mem data width.
- AXI_ID_WIDTH, 3, AXI ID width.
- MEM_ADDR_WIDTH, 32, mem address width; the mem address is the low MEM_ADDR_WIDTH bits of the AXI address.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- s_axi_aw{id,addr,len,size,burst,valid}  in  ID/ADDR/8/3/2/1  write address channel.
- s_axi_awready  out  1  write address ready.
- s_axi_w{data,strb,last,valid}  in  DATA/DATA/8/1/1  write data channel.
- s_axi_wready  out  1  write data ready.
- s_axi_b{id,resp,valid}  out  ID/2/1  write response channel.
- s_axi_bready  in  1  write response ready.
- s_axi_ar{id,addr,len,size,burst,valid}  in  ID/ADDR/8/3/2/1  read address channel.
- s_axi_arready  out  1  read address ready.
- s_axi_r{id,data,resp,last,valid}  out  ID/DATA/2/1/1  read data channel.
- s_axi_rready  in  1  read data ready.
- s_axi_{aw,ar}{lock,cache,prot,qos,region}  in  std  accepted and ignored.
- m_mem_req  out  1  request.
- m_mem_gnt  in  1  grant.
- m_mem_addr  out  MEM_ADDR  address.
- m_mem_we  out  1  write enable.
- m_mem_wdata  out  DATA  write data.
- m_mem_be  out  DATA/8  byte enables.
- m_mem_valid  in  1  response valid; asserted for both reads and writes.
- m_mem_rdata  in  DATA  read data.
- m_mem_error  in  1  response error.

Behaviour:
- Reset: synchronous, active-high on rst_i; it aborts any in-flight burst.
  - All ready/valid outputs and m_mem_req go to 0, and the FSM returns to IDLE.
  - rresp/bresp, rdata, beat counter and error flag clear to 0. Priority resets to write-first.
  - Mem responses still pending at reset are dropped.
- FSM states: IDLE, RD_REQ, RD_WAIT, RD_DATA, WR_REQ, WR_WAIT, WR_RESP.
- IDLE:
  - awready = 1 if the write is selected; arready = 1 if the read is selected.
  - With only one of awvalid/arvalid high, that one is selected.
  - With both high, priority alternates: the loser of the last conflict wins the next one. After reset, write wins.
  - On the handshake, latch id, addr, len, size, burst; clear the beat counter and the sticky error flag. Go to RD_REQ or WR_REQ.
- Address generation:
  - FIXED: address held for all beats.
  - INCR: address += (1 << size) after each beat, in AXI_ADDR_WIDTH arithmetic (wraps modulo 2^ADDR).
  - WRAP and reserved burst type 2'b11: treated as INCR.
- RD_REQ:
  - m_mem_req = 1, we = 0, be = all ones, addr = current.
  - req is held until gnt. On req & gnt go to RD_WAIT.
- RD_WAIT: on m_mem_valid, capture rdata and the error into the R register; go to RD_DATA.
- RD_DATA:
  - rvalid = 1; rid = latched id; rresp = 2'b10 if the beat error is set, else 2'b00; rlast = (beat == len).
  - On rready: if last beat, go to IDLE; otherwise increment beat and address and go to RD_REQ.
  - The next mem request is not issued before the R handshake, so rdata is always stable while rvalid is high.
- WR_REQ:
  - m_mem_req = wvalid; we = 1; wdata = s_axi_wdata; be = s_axi_wstrb.
  - wready = m_mem_gnt (the W beat is consumed in the grant cycle). On req & gnt go to WR_WAIT.
- WR_WAIT: on m_mem_valid, OR m_mem_error into the sticky flag.
  - If beat == len, go to WR_RESP.
  - Otherwise increment beat and address and go to WR_REQ.
- wlast is ignored: the beat count comes from awlen only.
- WR_RESP: bvalid = 1; bid = latched id; bresp = 2'b10 if the sticky flag is set, else 2'b00. On bready go to IDLE.
- A mem response arriving in the same cycle as the grant is not legal for the target; only responses one or more cycles after the grant are supported.
- Minimum latency (zero-wait grant, 1-cycle memory response):
  - Read: AR handshake at cycle N; req at N+1; valid at N+2; rvalid at N+3; per beat, 3 cycles.
  - Write: AW handshake at N; req/wready at N+1; bvalid at N+3 for a single beat.

Test Plan:
1. Single read: AR addr 0x100, len 0, id 5, mem returns 0xDEADBEEF -> one R beat with data 0xDEADBEEF, rid 5, rresp 0, rlast 1; m_mem_addr 0x100.
2. INCR read burst: addr 0x200, len 3, size 2 -> mem addresses 0x200, 0x204, 0x208, 0x20C; rlast only on beat 4; with rready held low 5 cycles on beat 2, rdata is stable and no mem req is issued meanwhile.
3. FIXED write burst: addr 0x40, len 2, strb 0x3/0xF/0x8 -> three mem writes at 0x40 with matching be and wdata; one B with bresp 0.
4. Write error: 4-beat write, m_mem_error on beat 2 only -> all 4 beats issued; single B with bresp 2'b10.
5. Arbitration: AW and AR valid together in the same cycle, repeated three times -> service order write, read, write.
6. Reset mid-burst: rst_i high during beat 2 of an 8-beat read -> next cycle rvalid = 0, m_mem_req = 0, FSM in IDLE; a new AR is accepted and serviced correctly afterwards.
